// File: rtl/pll_lock_supervisor_pkg.sv
// Shared definitions for the PLL lock supervisor: FSM state encodings and
// default qualification window lengths.
package pll_pkg;

    typedef logic [2:0] pll_state_t;

    localparam pll_state_t ST_WAIT_LOCK = 3'd0;
    localparam pll_state_t ST_STABLE    = 3'd1;
    localparam pll_state_t ST_HOLD      = 3'd2;
    localparam pll_state_t ST_RUN       = 3'd3;
    localparam pll_state_t ST_LOST      = 3'd4;

    localparam int DEFAULT_STABLE_CYCLES = 1024;
    localparam int DEFAULT_HOLD_CYCLES   = 16;

endpackage

// File: rtl/pll_lock_supervisor_sync_ff.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// The chain clears to 0 on reset so downstream logic sees "not asserted".
module sync_ff #(
    parameter int STAGES = 2
) (
    input  logic i_clock,
    input  logic i_reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [STAGES-1:0] r_sync;

    // Shift the async input through the flop chain, first stage at bit 0.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL lock flag (stable window, then hold-off) before releasing
// the datapath reset; records lock losses in a sticky flag and saturating count.
module pll_lock_supervisor
    import pll_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
    parameter int HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
    parameter int CNT_WIDTH     = 8
) (
    input  logic                 i_clock,
    input  logic                 i_reset_n,
    input  logic                 i_locked,
    input  logic                 i_clear_sticky,
    output logic                 o_rst_out_n,
    output logic                 o_ready,
    output logic                 o_lock_lost,
    output logic [CNT_WIDTH-1:0] o_loss_count
);

    // Window timer only needs to reach the larger of the two window lengths.
    localparam int TMR_MAX = (STABLE_CYCLES > HOLD_CYCLES) ? STABLE_CYCLES : HOLD_CYCLES;
    localparam int TW      = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TW-1:0]        STABLE_LAST = TW'(STABLE_CYCLES - 1);
    localparam logic [TW-1:0]        HOLD_LAST   = TW'(HOLD_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] LOSS_MAX    = '1;

    logic                 w_locked_s;
    pll_state_t           r_state;
    pll_state_t           w_next_state;
    logic [TW-1:0]        r_tmr;
    logic [TW-1:0]        w_next_tmr;
    logic                 w_run_next;
    logic                 w_loss_event;
    logic                 r_rst_out_n;
    logic                 r_lock_lost;
    logic [CNT_WIDTH-1:0] r_loss_count;

    sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_lock_sync (
        .i_clock   (i_clock),
        .i_reset_n (i_reset_n),
        .i_d       (i_locked),
        .o_q       (w_locked_s)
    );

    // State and window timer registers.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state <= ST_WAIT_LOCK;
            r_tmr   <= '0;
        end else begin
            r_state <= w_next_state;
            r_tmr   <= w_next_tmr;
        end
    end

    // Next-state logic: any drop before RUN simply restarts qualification.
    always_comb begin
        w_next_state = r_state;
        w_next_tmr   = '0;
        case (r_state)
            ST_WAIT_LOCK: begin
                if (w_locked_s) begin
                    w_next_state = ST_STABLE;
                end
            end
            ST_STABLE: begin
                if (!w_locked_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_tmr == STABLE_LAST) begin
                    w_next_state = ST_HOLD;
                end else begin
                    w_next_tmr = r_tmr + 1'b1;
                end
            end
            ST_HOLD: begin
                if (!w_locked_s) begin
                    w_next_state = ST_WAIT_LOCK;
                end else if (r_tmr == HOLD_LAST) begin
                    w_next_state = ST_RUN;
                end else begin
                    w_next_tmr = r_tmr + 1'b1;
                end
            end
            ST_RUN: begin
                if (!w_locked_s) begin
                    w_next_state = ST_LOST;
                end
            end
            ST_LOST: begin
                w_next_state = ST_WAIT_LOCK;
            end
            default: begin
                w_next_state = ST_WAIT_LOCK;
            end
        endcase
    end

    // Output decode: datapath runs only in RUN; leaving RUN is a loss event.
    always_comb begin
        w_run_next   = (w_next_state == ST_RUN);
        w_loss_event = (r_state == ST_RUN) && (w_next_state == ST_LOST);
    end

    // Registered datapath reset so it can only deassert on a clock edge.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_rst_out_n <= 1'b0;
        end else begin
            r_rst_out_n <= w_run_next;
        end
    end

    // Sticky loss status; a loss coincident with a clear is still recorded.
    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_lock_lost  <= 1'b0;
            r_loss_count <= '0;
        end else if (w_loss_event) begin
            r_lock_lost <= 1'b1;
            if (i_clear_sticky) begin
                r_loss_count <= CNT_WIDTH'(1);
            end else if (r_loss_count != LOSS_MAX) begin
                r_loss_count <= r_loss_count + 1'b1;
            end
        end else if (i_clear_sticky) begin
            r_lock_lost  <= 1'b0;
            r_loss_count <= '0;
        end
    end

    assign o_rst_out_n  = r_rst_out_n;
    assign o_ready      = r_rst_out_n;
    assign o_lock_lost  = r_lock_lost;
    assign o_loss_count = r_loss_count;

endmodule
